// File: rtl/vx_fpu_share_arb_pkg.sv
// Shared types for the FPU sharing arbiter: lock FSM states, tag-table entry and index sizing.
package vx_fpu_share_arb_pkg;

   typedef enum logic {
      ARB_OPEN,
      ARB_LOCKED
   } lock_state_t;

   // Owner field of a tag-table entry; wide enough for up to 256 requesters.
   localparam int OWNER_MAX_W = 8;
   typedef logic [OWNER_MAX_W-1:0] tag_entry_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_fpu_tag_alloc.sv
// FPU tag allocator: free mask, lowest-free-tag encoder and owner table with acquire/release.
module vx_fpu_tag_alloc
   import vx_fpu_share_arb_pkg::*;
#(
   parameter int TAG_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 acquire,
   input  logic [TAG_WIDTH-1:0] acquire_tag,
   input  tag_entry_t           acquire_owner,
   input  logic                 rel_valid,
   input  logic [TAG_WIDTH-1:0] rel_tag,
   input  logic [TAG_WIDTH-1:0] lookup_tag,
   output tag_entry_t           lookup_owner,
   output logic                 lookup_free,
   output logic [TAG_WIDTH-1:0] free_tag,
   output logic                 any_free,
   output logic                 all_free
);

   localparam int NUM_TAGS = 2 ** TAG_WIDTH;

   logic [NUM_TAGS-1:0] free_mask_reg, free_mask_next;
   tag_entry_t          owner_ram [NUM_TAGS];

   // Scan downwards so the lowest free index wins.
   always_comb begin
      free_tag = '0;
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
         if (free_mask_reg[t]) free_tag = TAG_WIDTH'(t);
      end
   end

   always_comb begin
      free_mask_next = free_mask_reg;
      if (rel_valid) free_mask_next[rel_tag] = 1'b1;
      if (acquire)   free_mask_next[acquire_tag] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) free_mask_reg <= '1;
      else       free_mask_reg <= free_mask_next;
   end

   always_ff @(posedge clk) begin
      if (acquire) owner_ram[acquire_tag] <= acquire_owner;
   end

   assign lookup_owner = owner_ram[lookup_tag];
   assign lookup_free  = free_mask_reg[lookup_tag];
   assign any_free     = |free_mask_reg;
   assign all_free     = &free_mask_reg;

endmodule

// File: rtl/vx_fpu_share_arb.sv
// Shares one tagged FPU core among NUM_REQS requesters: round-robin grant, per-requester
// credits, and a one-deep response register per requester for out-of-order returns.
module vx_fpu_share_arb
   import vx_fpu_share_arb_pkg::*;
#(
   parameter int NUM_REQS  = 4,
   parameter int REQ_DATAW = 256,
   parameter int RSP_DATAW = 133,
   parameter int TAG_WIDTH = 3,
   parameter int MAX_OUTST = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQS-1:0]           req_valid,
   input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
   output logic [NUM_REQS-1:0]           req_ready,
   output logic                          fpu_req_valid,
   output logic [REQ_DATAW-1:0]          fpu_req_data,
   output logic [TAG_WIDTH-1:0]          fpu_req_tag,
   input  logic                          fpu_req_ready,
   input  logic                          fpu_rsp_valid,
   input  logic [RSP_DATAW-1:0]          fpu_rsp_data,
   input  logic [TAG_WIDTH-1:0]          fpu_rsp_tag,
   output logic                          fpu_rsp_ready,
   output logic [NUM_REQS-1:0]           rsp_valid,
   output logic [NUM_REQS*RSP_DATAW-1:0] rsp_data,
   input  logic [NUM_REQS-1:0]           rsp_ready,
   output logic                          busy
);

   localparam int IDX_W = idx_width(NUM_REQS);
   localparam int CRD_W = $clog2(MAX_OUTST + 1);

   lock_state_t          state_reg, state_next;
   logic [IDX_W-1:0]     rr_ptr_reg, lock_grant_reg, open_grant, grant;
   logic [TAG_WIDTH-1:0] lock_tag_reg, free_tag, grant_tag;
   logic [NUM_REQS-1:0]  eligible, rsp_stall;
   logic                 open_found, any_free, all_free, lookup_free, locked;
   logic                 req_fire, rsp_fire;
   tag_entry_t           lookup_owner;

   vx_fpu_tag_alloc #(.TAG_WIDTH(TAG_WIDTH)) tag_alloc (
      .clk           (clk),
      .reset         (reset),
      .acquire       (req_fire),
      .acquire_tag   (grant_tag),
      .acquire_owner (tag_entry_t'(grant)),
      .rel_valid     (rsp_fire),
      .rel_tag       (fpu_rsp_tag),
      .lookup_tag    (fpu_rsp_tag),
      .lookup_owner  (lookup_owner),
      .lookup_free   (lookup_free),
      .free_tag      (free_tag),
      .any_free      (any_free),
      .all_free      (all_free)
   );

   always_comb begin
      int idx;
      idx        = 0;
      open_found = 1'b0;
      open_grant = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NUM_REQS) idx = idx - NUM_REQS;
         if (!open_found && eligible[idx]) begin
            open_found = 1'b1;
            open_grant = IDX_W'(idx);
         end
      end
   end

   // A stalled request keeps its grant and tag until the core accepts it.
   assign locked        = (state_reg == ARB_LOCKED);
   assign grant         = locked ? lock_grant_reg : open_grant;
   assign grant_tag     = locked ? lock_tag_reg : free_tag;
   assign fpu_req_valid = !reset && (locked || open_found);
   assign fpu_req_tag   = reset ? '0 : grant_tag;
   assign fpu_req_data  = reset ? '0 : req_data[grant*REQ_DATAW +: REQ_DATAW];
   assign req_fire      = fpu_req_valid && fpu_req_ready;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ARB_OPEN:   if (fpu_req_valid && !fpu_req_ready) state_next = ARB_LOCKED;
         ARB_LOCKED: if (fpu_req_ready) state_next = ARB_OPEN;
         default:    state_next = ARB_OPEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ARB_OPEN;
         rr_ptr_reg     <= '0;
         lock_grant_reg <= '0;
         lock_tag_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ARB_OPEN && state_next == ARB_LOCKED) begin
            lock_grant_reg <= open_grant;
            lock_tag_reg   <= free_tag;
         end
         if (req_fire) begin
            if (grant == IDX_W'(NUM_REQS - 1)) rr_ptr_reg <= '0;
            else                               rr_ptr_reg <= grant + 1'b1;
         end
      end
   end

   assign fpu_rsp_ready = !reset && !(|rsp_stall);
   assign rsp_fire      = fpu_rsp_valid && fpu_rsp_ready;
   assign busy          = !all_free || (|rsp_valid);

   generate
      for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
         logic                 valid_reg, load, drain, inc, owner_hit;
         logic [RSP_DATAW-1:0] data_reg;
         logic [CRD_W-1:0]     credit_reg;

         assign owner_hit     = (lookup_owner == tag_entry_t'(gi));
         assign load          = rsp_fire && owner_hit;
         assign drain         = valid_reg && rsp_ready[gi];
         assign inc           = req_fire && (grant == IDX_W'(gi));
         assign rsp_stall[gi] = owner_hit && valid_reg && !rsp_ready[gi];
         assign eligible[gi]  = req_valid[gi] && (credit_reg < CRD_W'(MAX_OUTST)) && any_free;
         assign req_ready[gi] = req_fire && (grant == IDX_W'(gi));
         assign rsp_valid[gi] = valid_reg;
         assign rsp_data[gi*RSP_DATAW +: RSP_DATAW] = data_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               valid_reg  <= 1'b0;
               data_reg   <= '0;
               credit_reg <= '0;
            end else begin
               if (load)       valid_reg <= 1'b1;
               else if (drain) valid_reg <= 1'b0;
               if (load)       data_reg <= fpu_rsp_data;
               if (inc && !drain)      credit_reg <= credit_reg + 1'b1;
               else if (drain && !inc) credit_reg <= credit_reg - 1'b1;
            end
         end

         assert property (@(posedge clk) disable iff (reset)
            !(inc && !drain && credit_reg == CRD_W'(MAX_OUTST)));
         assert property (@(posedge clk) disable iff (reset)
            !(drain && !inc && credit_reg == '0));
      end
   endgenerate

   assert property (@(posedge clk) disable iff (reset) !(fpu_rsp_valid && lookup_free));

endmodule
